// File: rtl/mem_pkg.sv
// Shared data-memory definitions: DM size ops, store-entry layout and word-index bounds.
// Pure declarations; no timing or flow-control content.
package mem_pkg;

    localparam logic [1:0] DM_WORD = 2'b00;
    localparam logic [1:0] DM_HALF = 2'b01;
    localparam logic [1:0] DM_BYTE = 2'b10;

    localparam int IDX_HI = 13;
    localparam int IDX_LO = 2;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Generic DEPTH-entry circular buffer; push lands at the clock edge, head is visible the next cycle.
// No internal backpressure: the caller must not push when full nor pop when empty.
module sb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wr_dat,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rd_dat,
    output logic [DEPTH-1:0][WIDTH-1:0] entries,
    output logic [DEPTH-1:0]            occupied,
    output logic [CW-1:0]               count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_dat  = (count == '0) ? '0 : mem[rd_ptr];
    assign entries = mem;

    // Slot i is live when its distance from the head is below the occupancy.
    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = (CW'(PW'(PW'(i) - rd_ptr)) < count);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write queue feeding the DM write port; a store is drainable the cycle after it is pushed.
// st_ready drops when full (no same-cycle slot reuse); loads hitting a queued word are stalled.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int IDX_LO = mem_pkg::IDX_LO,
    parameter int IDX_HI = mem_pkg::IDX_HI,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [1:0]    st_op,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_wdata,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    output logic          ld_stall,
    input  logic          dm_grant,
    output logic          dm_write,
    output logic [1:0]    dm_op,
    output logic [31:0]   dm_addr,
    output logic [31:0]   dm_wd,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          misalign_err
);

    import mem_pkg::*;

    sb_entry_t              wr_e;
    sb_entry_t              rd_e;
    sb_entry_t [DEPTH-1:0]  ents;
    logic [DEPTH-1:0]       occ;
    logic                   aligned;
    logic                   push;
    logic                   hit_q;

    always_comb begin
        case (st_op)
            DM_HALF: aligned = ~st_addr[0];
            DM_BYTE: aligned = 1'b1;
            default: aligned = (st_addr[1:0] == 2'b00);
        endcase
    end

    assign st_ready = (count != CW'(DEPTH));
    assign push     = st_valid && st_ready && aligned;
    assign empty    = (count == '0);
    assign dm_write = !empty && dm_grant;

    assign wr_e = '{op: st_op, addr: st_addr, wdata: st_wdata};

    sb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(sb_entry_t))
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_dat   (wr_e),
        .pop      (dm_write),
        .rd_dat   (rd_e),
        .entries  (ents),
        .occupied (occ),
        .count    (count)
    );

    assign dm_op   = rd_e.op;
    assign dm_addr = rd_e.addr;
    assign dm_wd   = rd_e.wdata;

    // Word-granular compare only: size and lane are ignored, so partial overlaps stall too.
    always_comb begin
        hit_q = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (ents[i].addr[IDX_HI:IDX_LO] == ld_addr[IDX_HI:IDX_LO])) begin
                hit_q = 1'b1;
            end
        end
    end

    assign ld_stall = ld_valid &&
                      (hit_q || (push && (st_addr[IDX_HI:IDX_LO] == ld_addr[IDX_HI:IDX_LO])));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err <= 1'b0;
        end else if (st_valid && st_ready && !aligned) begin
            misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed vector bench for store_buffer: per-cycle stimulus with hand-computed outputs,
// plus hand sequences for reset behaviour.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        dm_grant;
    logic        dm_write;
    logic [1:0]  dm_op;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [2:0]  count;
    logic        empty;
    logic        misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_op        (st_op),
        .st_addr      (st_addr),
        .st_wdata     (st_wdata),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_stall     (ld_stall),
        .dm_grant     (dm_grant),
        .dm_write     (dm_write),
        .dm_op        (dm_op),
        .dm_addr      (dm_addr),
        .dm_wd        (dm_wd),
        .count        (count),
        .empty        (empty),
        .misalign_err (misalign_err)
    );

    typedef struct {
        logic        sv;
        logic [1:0]  op;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic        g;
        logic        rdy;
        logic        stall;
        logic        wr;
        logic [1:0]  dop;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic [2:0]  cnt;
        logic        mis;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(
        input logic sv, input logic [1:0] op, input logic [31:0] sa, input logic [31:0] sd,
        input logic lv, input logic [31:0] la, input logic g,
        input logic rdy, input logic stall, input logic wr, input logic [1:0] dop,
        input logic [31:0] daddr, input logic [31:0] dwd, input logic [2:0] cnt, input logic mis);
        vec_t r;
        r.sv = sv; r.op = op; r.sa = sa; r.sd = sd; r.lv = lv; r.la = la; r.g = g;
        r.rdy = rdy; r.stall = stall; r.wr = wr; r.dop = dop; r.daddr = daddr;
        r.dwd = dwd; r.cnt = cnt; r.mis = mis;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [1:0] op, input logic [31:0] sa,
                         input logic [31:0] sd, input logic lv, input logic [31:0] la,
                         input logic g);
        st_valid = sv; st_op = op; st_addr = sa; st_wdata = sd;
        ld_valid = lv; ld_addr = la; dm_grant = g;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [73:0] act_v;
        logic [73:0] exp_v;

        // Single store then drain
        tv.push_back(v(1,0,'h10,'hDEADBEEF,0,0,1, 1,0,0,0,0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,0,1,0,'h10,'hDEADBEEF,1,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));
        // Fill with grant low, hold 5th store, then drain in order
        tv.push_back(v(1,0,'h100,1,0,0,0, 1,0,0,0,0,0,0,0));
        tv.push_back(v(1,1,'h102,2,0,0,0, 1,0,0,0,'h100,1,1,0));
        tv.push_back(v(1,2,'h103,3,0,0,0, 1,0,0,0,'h100,1,2,0));
        tv.push_back(v(1,0,'h104,4,0,0,0, 1,0,0,0,'h100,1,3,0));
        tv.push_back(v(1,0,'h108,5,0,0,0, 0,0,0,0,'h100,1,4,0));
        tv.push_back(v(1,0,'h108,5,0,0,1, 0,0,1,0,'h100,1,4,0));
        tv.push_back(v(1,0,'h108,5,0,0,1, 1,0,1,1,'h102,2,3,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,0,1,2,'h103,3,3,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,0,1,0,'h104,4,2,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,0,1,0,'h108,5,1,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));
        // Mixed push/pop across pointer wrap
        tv.push_back(v(1,0,'h20,'hA0,0,0,0, 1,0,0,0,0,0,0,0));
        tv.push_back(v(1,0,'h24,'hA1,0,0,0, 1,0,0,0,'h20,'hA0,1,0));
        tv.push_back(v(1,0,'h28,'hA2,0,0,1, 1,0,1,0,'h20,'hA0,2,0));
        tv.push_back(v(1,0,'h2C,'hA3,0,0,1, 1,0,1,0,'h24,'hA1,2,0));
        tv.push_back(v(1,0,'h30,'hA4,0,0,1, 1,0,1,0,'h28,'hA2,2,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,0,1,0,'h2C,'hA3,2,0));
        tv.push_back(v(1,0,'h34,'hA5,0,0,0, 1,0,0,0,'h30,'hA4,1,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,0,1,0,'h30,'hA4,2,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,0,1,0,'h34,'hA5,1,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));
        // Load hazard: same-cycle push, queued entry, other word, aliased upper bits, popping, drained
        tv.push_back(v(1,2,'h203,'h5A,1,'h200,0, 1,1,0,0,0,0,0,0));
        tv.push_back(v(0,0,0,0,1,'h200,0, 1,1,0,2,'h203,'h5A,1,0));
        tv.push_back(v(0,0,0,0,1,'h204,0, 1,0,0,2,'h203,'h5A,1,0));
        tv.push_back(v(0,0,0,0,1,'h4200,0, 1,1,0,2,'h203,'h5A,1,0));
        tv.push_back(v(0,0,0,0,1,'h200,1, 1,1,1,2,'h203,'h5A,1,0));
        tv.push_back(v(0,0,0,0,1,'h200,0, 1,0,0,0,0,0,0,0));
        // Misaligned half store, then five stores with the sticky flag held
        tv.push_back(v(1,1,'h1,7,0,0,0, 1,0,0,0,0,0,0,0));
        tv.push_back(v(1,0,'h40,'h11,0,0,0, 1,0,0,0,0,0,0,1));
        tv.push_back(v(1,2,'h41,'h12,0,0,0, 1,0,0,0,'h40,'h11,1,1));
        tv.push_back(v(1,1,'h42,'h13,0,0,0, 1,0,0,0,'h40,'h11,2,1));
        tv.push_back(v(1,0,'h46,'h14,0,0,0, 1,0,0,0,'h40,'h11,3,1));
        tv.push_back(v(1,3,'h48,'h15,0,0,0, 1,0,0,0,'h40,'h11,3,1));
        tv.push_back(v(0,0,0,0,0,0,1, 0,0,1,0,'h40,'h11,4,1));

        // Reset state, with grant high so a spurious write would show
        reset = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 1);
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_dm_write", 32'(dm_write), 0);
        chk("rst_st_ready", 32'(st_ready), 1);
        chk("rst_ld_stall", 32'(ld_stall), 0);
        chk("rst_misalign", 32'(misalign_err), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].sv, tv[i].op, tv[i].sa, tv[i].sd, tv[i].lv, tv[i].la, tv[i].g);
            #3;
            act_v = {st_ready, ld_stall, dm_write, dm_op, dm_addr, dm_wd, count, empty, misalign_err};
            exp_v = {tv[i].rdy, tv[i].stall, tv[i].wr, tv[i].dop, tv[i].daddr, tv[i].dwd,
                     tv[i].cnt, (tv[i].cnt == 3'd0), tv[i].mis};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL vec%0d: got rdy=%b stall=%b wr=%b op=%0d addr=%h wd=%h cnt=%0d empty=%b mis=%b expected rdy=%b stall=%b wr=%b op=%0d addr=%h wd=%h cnt=%0d mis=%b",
                         i, st_ready, ld_stall, dm_write, dm_op, dm_addr, dm_wd, count, empty,
                         misalign_err, tv[i].rdy, tv[i].stall, tv[i].wr, tv[i].dop,
                         tv[i].daddr, tv[i].dwd, tv[i].cnt, tv[i].mis);
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while draining with three entries queued
        drive(0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("pre_rst_count", 32'(count), 3);
        chk("pre_rst_dm_write", 32'(dm_write), 1);
        chk("pre_rst_dm_addr", dm_addr, 32'h41);
        reset = 1'b0;
        #1;
        chk("mid_rst_dm_write", 32'(dm_write), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_misalign", 32'(misalign_err), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(1, 0, 32'h80, 32'hCAFE_F00D, 0, 0, 1);
        chk("post_rst_no_bypass", 32'(dm_write), 0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("post_rst_dm_write", 32'(dm_write), 1);
        chk("post_rst_dm_addr", dm_addr, 32'h80);
        chk("post_rst_dm_wd", dm_wd, 32'hCAFE_F00D);
        chk("post_rst_count", 32'(count), 1);
        @(posedge clk);
        #3;
        chk("post_rst_drained", 32'(count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write queue between the MEM-stage store path and the data memory's single write port.
- Pipeline stores retire into the queue in one cycle and do not wait for the DM port.
- The queue drains in order, one entry per granted cycle, presenting write enable, op, address and data to the DM.
- A conservative word-address hazard check stalls any load that would read a word still pending in the queue.

Parameters:
- DEPTH, 4: number of queue entries; must be a power of two and at least 2.
- IDX_LO, 2: low bit of the word index used for hazard compare.
- IDX_HI, 13: high bit of the word index used for hazard compare (matches DM word indexing).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  queue can accept a store this cycle
- st_op  in  2  size: 00 word, 01 half, 10 byte, 11 treated as word
- st_addr  in  32  byte address of store
- st_wdata  in  32  store data, right-aligned for half/byte
- ld_valid  in  1  load present in MEM stage
- ld_addr  in  32  byte address of load
- ld_stall  out  1  load must hold: word hazard with queued data
- dm_grant  in  1  DM write port free this cycle
- dm_write  out  1  DM write enable
- dm_op  out  2  DM size op (same encoding as st_op)
- dm_addr  out  32  DM byte address
- dm_wd  out  32  DM write data (right-aligned, DM performs lane merge)
- count  out  $clog2(DEPTH+1)  occupied entries
- empty  out  1  count == 0
- misalign_err  out  1  sticky: a misaligned store was rejected

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - wr_ptr, rd_ptr, count and misalign_err clear to 0.
  - Outputs immediately read count=0, empty=1, dm_write=0, ld_stall=0, st_ready=1, misalign_err=0.
  - Entry payloads need not clear.
- Reset asserted mid-drain: the in-flight dm_write drops at once and queued stores are discarded.
- Push:
  - Occurs when st_valid && st_ready && aligned; payload {op, addr, wdata} is written at wr_ptr on the clock edge.
  - wr_ptr increments modulo DEPTH.
- Pop:
  - Occurs when dm_write, where dm_write = !empty && dm_grant.
  - rd_ptr increments modulo DEPTH.
  - dm_op, dm_addr and dm_wd are driven combinationally from the entry at rd_ptr. They are don't-care when empty; the drive value is 0.
- Pointer width is log2(DEPTH); count width holds 0..DEPTH.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- st_ready = (count != DEPTH):
  - No bypass when full; a pop in the same cycle does not open a slot until the next cycle.
  - The upstream stage holds its store while st_ready=0.
- No store-to-DM bypass when empty: minimum latency is push at edge N, with dm_write possible in cycle N+1.
- Alignment:
  - A word store requires addr[1:0]==0; a half store requires addr[0]==0; bytes are always aligned.
  - A misaligned store with st_valid && st_ready is consumed without enqueue and sets misalign_err, which stays set until reset.
- ld_stall is combinational and asserted when ld_valid and either condition holds:
  - any occupied entry has addr[IDX_HI:IDX_LO] == ld_addr[IDX_HI:IDX_LO];
  - a store is being pushed this cycle to the same word.
- Hazard compare ignores size and byte lane (conservative). An entry popping this cycle still counts as occupied for the compare.
- Ordering: drain order equals push order; no coalescing.

Decomposition:
- Shared package mem_pkg: DM op constants DM_WORD=2'b00, DM_HALF=2'b01, DM_BYTE=2'b10; the store-entry struct {op[1:0], addr[31:0], wdata[31:0]}; word-index bounds IDX_HI and IDX_LO.
- One natural sub-module, sb_fifo:
  - generic DEPTH-entry circular buffer with pointers and count, async active-low reset;
  - store_buffer adds the alignment check, hazard CAM and DM-side signals.

Test Plan:
- Reset then single store:
  - Stimulus: word store addr=0x0000_0010, data=0xDEAD_BEEF, dm_grant=1.
  - Required: count=1 next cycle; dm_write=1, dm_addr=0x10, dm_wd=0xDEADBEEF, dm_op=00; count=0 after the following edge.
- Fill with dm_grant=0:
  - Stimulus: push 4 stores.
  - Required: st_ready=0 and count=4; a 5th st_valid is held.
  - Then raise dm_grant: entries drain in push order over 4 cycles, and st_ready returns to 1 after the first pop.
- Simultaneous push/pop:
  - Stimulus: count=2, push and grant in the same cycle.
  - Required: count stays 2; pointer wrap past DEPTH-1 preserves FIFO order over 10 mixed operations.
- Hazard:
  - Stimulus: queue holds byte store addr=0x0000_0203; ld_addr=0x0000_0200.
  - Required: ld_stall=1; ld_addr=0x0000_0204 gives ld_stall=0; after that entry drains, ld_stall=0 for 0x200.
- Misalign:
  - Stimulus: half store at addr=0x0000_0001.
  - Required: not enqueued (count unchanged) and misalign_err=1, staying set across 5 subsequent valid stores.
- Async reset mid-drain:
  - Stimulus: count=3, dm_grant=1; assert reset between edges.
  - Required: dm_write=0 and count=0 immediately; after release, the first new store drains correctly.
